// File: rtl/riscv_icache_line_buf.sv
// Single-line instruction cache: answers fetches from a LINE_WORDS-word buffer and refills it by burst on a miss.
// Optional: define ICACHE_LINE_EARLY_RESTART_EN to answer as soon as the requested word arrives during a fill.
module riscv_icache_line_buf #(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] USER_LIMIT = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_rd_i,
  input  logic [31:0] req_pc_i,
  input  logic [1:0]  req_priv_i,
  input  logic        req_flush_i,
  input  logic        req_invalidate_i,
  output logic        req_accept_o,
  output logic        req_valid_o,
  output logic [31:0] req_inst_o,
  output logic        req_error_o,
  output logic        req_page_fault_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_len_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_error_i
);

  localparam int IW  = $clog2(LINE_WORDS);
  localparam int OFF = IW + 2;
  localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL, ST_RESP} state_t;

  state_t         state_q;
  logic [31:0]    line_q [LINE_WORDS];
  logic [31:OFF]  tag_q;
  logic           line_valid_q;
  logic           flush_pend_q;
  logic           err_q;
  logic [IW-1:0]  cnt_q;
  logic [31:2]    pc_q;
  logic [31:0]    mem_addr_q;
  logic           valid_q;
  logic [31:0]    inst_q;
  logic           error_q;
  logic           pf_q;

  logic           flush;
  logic           hit;
  logic           fault;
  logic [IW-1:0]  req_idx;
  logic [IW-1:0]  pc_idx;
  logic [31:0]    fill_word;
  logic           fill_err;
  logic           unused_pc_lsbs;

  assign flush          = req_flush_i | req_invalidate_i;
  assign req_idx        = req_pc_i[OFF-1:2];
  assign pc_idx         = pc_q[OFF-1:2];
  assign hit            = line_valid_q && (tag_q == req_pc_i[31:OFF]);
  assign fault          = (req_priv_i == 2'b00) && (req_pc_i >= USER_LIMIT);
  assign unused_pc_lsbs = ^req_pc_i[1:0];

  // On the last beat the requested word may be the one arriving right now.
  assign fill_word = (pc_idx == cnt_q) ? mem_data_i : line_q[pc_idx];
  assign fill_err  = err_q | mem_error_i;

  assign req_accept_o     = (state_q == ST_IDLE);
  assign mem_rd_o         = (state_q == ST_REQ);
  assign mem_addr_o       = mem_addr_q;
  assign mem_len_o        = 8'(LINE_WORDS - 1);
  assign req_valid_o      = valid_q;
  assign req_inst_o       = inst_q;
  assign req_error_o      = error_q;
  assign req_page_fault_o = pf_q;

  // NOTE: the data array has no reset; line_valid_q alone guards its contents.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_FILL && mem_valid_i) line_q[cnt_q] <= mem_data_i;
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      pc_q         <= '0;
      mem_addr_q   <= '0;
      valid_q      <= 1'b0;
      inst_q       <= '0;
      error_q      <= 1'b0;
      pf_q         <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      pf_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_rd_i && fault) begin
            valid_q <= 1'b1;
            inst_q  <= '0;
            pf_q    <= 1'b1;
          end else if (req_rd_i && hit && !flush) begin
            valid_q <= 1'b1;
            inst_q  <= line_q[req_idx];
          end else if (req_rd_i) begin
            pc_q         <= req_pc_i[31:2];
            mem_addr_q   <= {req_pc_i[31:OFF], OFF'(0)};
            line_valid_q <= 1'b0;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_accept_i) begin
            cnt_q   <= '0;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_valid_i) begin
            cnt_q <= cnt_q + IW'(1);
            err_q <= fill_err;
`ifdef ICACHE_LINE_EARLY_RESTART_EN
            if (cnt_q == pc_idx) begin
              valid_q <= 1'b1;
              inst_q  <= mem_data_i;
              error_q <= mem_error_i;
            end
`endif
            if (cnt_q == LAST_BEAT) begin
              state_q <= ST_RESP;
              if (!fill_err && !flush_pend_q) begin
                line_valid_q <= 1'b1;
                tag_q        <= pc_q[31:OFF];
              end
`ifndef ICACHE_LINE_EARLY_RESTART_EN
              valid_q <= 1'b1;
              inst_q  <= fill_word;
              error_q <= fill_err;
`endif
            end
          end
        end
        ST_RESP: begin
          err_q        <= 1'b0;
          flush_pend_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Flush overrides any validation above; mid-fill it also blocks the in-flight line.
      if (flush) line_valid_q <= 1'b0;
      if (flush && (state_q == ST_REQ || state_q == ST_FILL)) flush_pend_q <= 1'b1;
    end
  end

endmodule

// File: doc/riscv_icache_line_buf.md
# riscv_icache_line_buf

Single-line instruction cache responder that terminates the fetch unit's `icache_*` request interface. It accepts one fetch request at a time and answers from a LINE_WORDS-word line buffer on a hit. On a miss it refills the buffer from a burst read port toward memory, then answers. It sits between the fetch stage and the instruction-side memory port, and replaces a direct fetch-to-memory connection.

## Interface
Parameters:
- LINE_WORDS, 4, words per line; power of 2, 2..16.
- USER_LIMIT, 32'h8000_0000, user-mode (priv 2'b00) fetches at PC >= this value fault.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_rd_i  in  1  fetch request strobe.
- req_pc_i  in  32  fetch PC; bits [1:0] ignored.
- req_priv_i  in  2  privilege level of the request.
- req_flush_i  in  1  flush the line buffer.
- req_invalidate_i  in  1  invalidate the line buffer; same effect as flush.
- req_accept_o  out  1  request accepted when high together with req_rd_i.
- req_valid_o  out  1  one-cycle response strobe.
- req_inst_o  out  32  instruction word.
- req_error_o  out  1  bus error on the response.
- req_page_fault_o  out  1  privilege fault on the response.
- mem_rd_o  out  1  burst read request; held until accepted.
- mem_addr_o  out  32  line-aligned burst address.
- mem_len_o  out  8  beats minus one; constant LINE_WORDS-1.
- mem_accept_i  in  1  memory accepts the burst request.
- mem_valid_i  in  1  read data beat valid.
- mem_data_i  in  32  read data.
- mem_error_i  in  1  error on this beat.

## Operation
- State: buffer `line_q[LINE_WORDS]`, `tag_q[31:log2(LINE_WORDS)+2]`, `line_valid_q`, `flush_pend_q`, beat counter, captured request PC.
- FSM states: IDLE, REQ, FILL, RESP.
- IDLE: `req_accept_o`=1.
  - rd with privilege fault (priv==0 and PC>=USER_LIMIT): respond with page_fault=1, inst=0, no memory access.
  - rd with hit (line_valid_q and tag match): respond with the buffered word.
  - rd with miss: capture PC, go to REQ.
- REQ: `mem_rd_o`=1, `mem_addr_o`={PC[31:log2(LINE_WORDS)+2], 0}. On mem_accept_i go to FILL with beat counter at 0.
- FILL: each mem_valid_i writes `line_q[counter]`, increments the counter, and ORs mem_error_i into the line error flag.
  - On the last beat (counter==LINE_WORDS-1) go to RESP.
  - Set line_valid_q and tag_q only if there was no error and no flush is pending.
- RESP: one cycle. Drive req_valid_o=1 with the requested word and req_error_o=line error flag. Return to IDLE; clear the error flag and flush_pend_q.
- req_accept_o=0 in REQ, FILL and RESP, so only one request is outstanding at a time.
- Flush/invalidate:
  - In IDLE: clears line_valid_q the same cycle.
  - In REQ/FILL: clears line_valid_q and sets flush_pend_q; the fill completes and the response is still delivered.
  - Simultaneous with rd in IDLE: flush wins, and the request is treated as a miss.
- Response outputs hold their last value when req_valid_o=0; error and page_fault are cleared to 0 on every non-response cycle.

## Timing
- Reset values:
  - req_accept_o=1, req_valid_o=0, req_inst_o=0, req_error_o=0, req_page_fault_o=0.
  - mem_rd_o=0, mem_addr_o=0.
  - line_valid_q=0, FSM in IDLE.
- Hit or fault: accepted at cycle N, req_valid_o at N+1. Back-to-back hits give one response per cycle.
- Miss:
  - mem_rd_o is asserted from N+1 until the mem_accept_i cycle.
  - Beats may arrive from the cycle after acceptance and may be non-contiguous.
  - req_valid_o is asserted the cycle after the last beat.
- Reset asserted mid-fill: the FSM returns to IDLE and the line is invalid. Beats arriving after reset deasserts are ignored in IDLE.
- A mem_valid_i outside FILL is ignored.

## Configuration
- ICACHE_LINE_EARLY_RESTART_EN defined:
  - In FILL, req_valid_o pulses the cycle after the beat at index PC[log2(LINE_WORDS)+1:2] arrives, carrying that beat's data and error.
  - The fill continues to completion. RESP still occurs but does not pulse req_valid_o.
  - req_accept_o stays 0 until IDLE.
- Not defined: the response is issued only in RESP, after the last beat.

## Test plan
- Reset, then rd PC=0x100 (miss); memory accepts after 2 cycles and returns 4 beats 0xA0..0xA3 -> mem_addr_o=0x100, mem_len_o=3; req_valid_o=1 with inst=0xA0 the cycle after beat 3.
- Follow with rd 0x104, then 0x108 on consecutive cycles -> responses 0xA1, 0xA2 at N+1 and N+2; no mem_rd_o.
- Miss at 0x20C with mem_error_i on beat 1 -> response error=1; next rd 0x200 misses again (mem_rd_o reasserted).
- req_flush_i during FILL of 0x300 -> response delivered; a subsequent rd 0x300 misses.
- priv=0, PC=0x8000_0000 -> page_fault=1, inst=0 at N+1; no mem_rd_o. The same PC with priv=3 -> normal miss.
- With ICACHE_LINE_EARLY_RESTART_EN, rd 0x408 -> req_valid_o the cycle after beat 2; accept stays low until after beat 3.
